// File: rtl/tcam_search_engine_if.sv
// Command/result handshake plus the SDRAM controller Avalon-MM port of the TCAM search engine.
// The engine connects through the slave modport; the command source and controller side use master.
interface tcam_search_engine_if #(
  parameter int ADDR_WID = 27,
  parameter int DATA_WID = 32,
  parameter int IDX_WID  = 4
);
  logic                cmd_vld;
  logic                cmd_rdy;
  logic [1:0]          cmd_op;
  logic [ADDR_WID-1:0] cmd_addr;
  logic [DATA_WID-1:0] cmd_key;
  logic [DATA_WID-1:0] cmd_mask;
  logic                res_vld;
  logic                res_hit;
  logic [IDX_WID-1:0]  res_index;
  logic                mem_init;
  logic                mem_read;
  logic                mem_write;
  logic [ADDR_WID-1:0] mem_address;
  logic [DATA_WID-1:0] mem_writedata;
  logic [DATA_WID-1:0] mem_readdata;
  logic                mem_initcomplete;
  logic                mem_waitrequest;
  logic                mem_readdatavalid;

  modport slave (
    input  cmd_vld, cmd_op, cmd_addr, cmd_key, cmd_mask,
           mem_readdata, mem_initcomplete, mem_waitrequest, mem_readdatavalid,
    output cmd_rdy, res_vld, res_hit, res_index,
           mem_init, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output cmd_vld, cmd_op, cmd_addr, cmd_key, cmd_mask,
           mem_readdata, mem_initcomplete, mem_waitrequest, mem_readdatavalid,
    input  cmd_rdy, res_vld, res_hit, res_index,
           mem_init, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/tcam_search_engine.sv
// TCAM command front end: SEARCH/UPDATE/INIT turned into single-word controller transactions; TCAM_TERNARY_MASK_EN enables the don't-care mask.
// Latency: strobe one cycle after accept when the controller is free; SEARCH costs issue + ack + read + compare per entry.
// Backpressure: cmd_rdy only in IDLE (no queuing); ISSUE holds off while mem_waitrequest is high.
module tcam_search_engine #(
  parameter int ADDR_WID = 27,
  parameter int DATA_WID = 32,
  parameter int IDX_WID  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tcam_search_engine_if.slave  bus
);

  localparam logic [1:0] OP_SEARCH = 2'd0;
  localparam logic [1:0] OP_UPDATE = 2'd1;
  localparam logic [1:0] OP_INIT   = 2'd2;
  localparam logic [1:0] OP_NOP    = 2'd3;

  typedef enum logic [2:0] {
    IDLE, ISSUE, ACK, WAIT_RD, WAIT_WR, WAIT_INIT, COMPARE, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_WID-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_WID-1:0] key_q, key_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic [IDX_WID-1:0]  idx_q, idx_d, res_idx_q, res_idx_d;
  logic                res_hit_q, res_hit_d;
  logic                rd_q, rd_d, wr_q, wr_d, init_q, init_d;
  logic                match;

`ifdef TCAM_TERNARY_MASK_EN
  logic [DATA_WID-1:0] mask_q, mask_d;
  assign match = ((rdata_q ^ key_q) & ~mask_q) == '0;
`else
  logic unused_mask;
  assign unused_mask = ^bus.cmd_mask;
  assign match = (rdata_q == key_q);
`endif

  assign bus.cmd_rdy       = (state_q == IDLE);
  assign bus.res_vld       = (state_q == DONE);
  assign bus.res_hit       = res_hit_q;
  assign bus.res_index     = res_idx_q;
  assign bus.mem_init      = init_q;
  assign bus.mem_read      = rd_q;
  assign bus.mem_write     = wr_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writedata = wdata_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    base_d    = base_q;
    addr_d    = addr_q;
    key_d     = key_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    res_idx_d = res_idx_q;
    res_hit_d = res_hit_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    init_d    = 1'b0;
`ifdef TCAM_TERNARY_MASK_EN
    mask_d    = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_vld) begin
          op_d      = bus.cmd_op;
          base_d    = bus.cmd_addr;
          key_d     = bus.cmd_key;
`ifdef TCAM_TERNARY_MASK_EN
          mask_d    = bus.cmd_mask;
`endif
          idx_d     = '0;
          res_hit_d = 1'b0;
          res_idx_d = '0;
          state_d   = (bus.cmd_op == OP_NOP) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.mem_waitrequest) begin
          state_d = ACK;
          case (op_q)
            OP_SEARCH: begin
              rd_d   = 1'b1;
              addr_d = base_q + ADDR_WID'(idx_q);
            end
            OP_UPDATE: begin
              wr_d    = 1'b1;
              addr_d  = base_q;
              wdata_d = key_q;
            end
            OP_INIT: init_d  = 1'b1;
            default: state_d = DONE;
          endcase
        end
      end
      // Controller registers its inputs, so busy rises a couple of cycles after the strobe.
      ACK: begin
        if (bus.mem_waitrequest) begin
          case (op_q)
            OP_SEARCH: state_d = WAIT_RD;
            OP_UPDATE: state_d = WAIT_WR;
            default:   state_d = WAIT_INIT;
          endcase
        end
      end
      WAIT_RD: begin
        if (bus.mem_readdatavalid) begin
          rdata_d = bus.mem_readdata;
          state_d = COMPARE;
        end
      end
      WAIT_WR: if (!bus.mem_waitrequest) state_d = DONE;
      WAIT_INIT: if (bus.mem_initcomplete) state_d = DONE;
      COMPARE: begin
        if (match) begin
          res_hit_d = 1'b1;
          res_idx_d = idx_q;
          state_d   = DONE;
        end else if (idx_q == '1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_WID'(1);
          state_d = ISSUE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      key_q     <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      idx_q     <= '0;
      res_idx_q <= '0;
      res_hit_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      init_q    <= 1'b0;
`ifdef TCAM_TERNARY_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      key_q     <= key_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      res_idx_q <= res_idx_d;
      res_hit_q <= res_hit_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      init_q    <= init_d;
`ifdef TCAM_TERNARY_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_tcam_search_engine.sv
// Directed bench for tcam_search_engine with a small controller model; expected strobes and results go
// into queues at issue time and are popped by monitors when the DUT presents them.
module tb_tcam_search_engine;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int IW = 4;

  localparam logic [2:0] K_INIT  = 3'b100;
  localparam logic [2:0] K_READ  = 3'b010;
  localparam logic [2:0] K_WRITE = 3'b001;

  typedef struct {
    logic [1:0]    op;
    logic          hit;
    logic [IW-1:0] idx;
  } res_t;

  typedef struct {
    logic [2:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } memx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcam_search_engine_if #(.ADDR_WID(AW), .DATA_WID(DW), .IDX_WID(IW)) bus ();

  tcam_search_engine #(.ADDR_WID(AW), .DATA_WID(DW), .IDX_WID(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  res_t  res_q[$];
  memx_t memx_q[$];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return 32'h0BAD_0000;
  endfunction

  // Controller model: registered inputs, busy for a few cycles, level status when idle.
  initial begin
    logic [2:0]    k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.mem_waitrequest   = 1'b0;
    bus.mem_readdatavalid = 1'b1;
    bus.mem_initcomplete  = 1'b0;
    bus.mem_readdata      = '0;
    forever begin
      @(negedge clk);
      k = {bus.mem_init, bus.mem_read, bus.mem_write};
      if (k != 3'b000) begin
        a = bus.mem_address;
        d = bus.mem_writedata;
        @(negedge clk);
        bus.mem_waitrequest   = 1'b1;
        bus.mem_readdatavalid = 1'b0;
        if (k[2]) bus.mem_initcomplete = 1'b0;
        repeat (3) @(negedge clk);
        if (k[0]) mem_arr[a] = d;
        if (k[1]) bus.mem_readdata = mem_rd(a);
        if (k[2]) bus.mem_initcomplete = 1'b1;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdatavalid = 1'b1;
      end
    end
  end

  memx_t em;
  always @(negedge clk) begin
    if (!rst && (bus.mem_init || bus.mem_read || bus.mem_write)) begin
      if (memx_q.size() == 0) begin
        fail("unexpected controller strobe");
      end else begin
        em = memx_q.pop_front();
        check("strobe kind", {61'd0, bus.mem_init, bus.mem_read, bus.mem_write}, {61'd0, em.kind});
        if (em.kind != K_INIT) check("mem_address", 64'(bus.mem_address), 64'(em.addr));
        if (em.kind == K_WRITE) check("mem_writedata", 64'(bus.mem_writedata), 64'(em.data));
      end
    end
  end

  res_t er;
  always @(negedge clk) begin
    if (!rst && bus.res_vld) begin
      if (res_q.size() == 0) begin
        fail("unexpected res_vld");
      end else begin
        er = res_q.pop_front();
        check("res_hit", 64'(bus.res_hit), 64'(er.hit));
        check("res_index", 64'(bus.res_index), 64'(er.idx));
        if (er.op == 2'd2) check("init done before result", 64'(bus.mem_initcomplete), 64'd1);
        if (er.op == 2'd1) check("write done before result", 64'(bus.mem_waitrequest), 64'd0);
      end
    end
  end

  task automatic exp_mem(input logic [2:0] k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    memx_t m;
    m.kind = k;
    m.addr = a;
    m.data = d;
    memx_q.push_back(m);
  endtask

  task automatic exp_res(input logic [1:0] op, input logic hit, input logic [IW-1:0] idx);
    res_t r;
    r.op  = op;
    r.hit = hit;
    r.idx = idx;
    res_q.push_back(r);
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] k,
                      input logic [DW-1:0] m);
    @(negedge clk);
    check("cmd_rdy when idle", 64'(bus.cmd_rdy), 64'd1);
    bus.cmd_vld  = 1'b1;
    bus.cmd_op   = op;
    bus.cmd_addr = a;
    bus.cmd_key  = k;
    bus.cmd_mask = m;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    check("cmd_rdy when busy", 64'(bus.cmd_rdy), 64'd0);
    if (op != 2'd3) begin
      @(negedge clk);
      check("strobe one cycle after accept",
            64'(bus.mem_init | bus.mem_read | bus.mem_write), 64'd1);
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((res_q.size() != 0 || memx_q.size() != 0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (res_q.size() != 0 || memx_q.size() != 0) begin
      fail({name, " timeout"});
      res_q.delete();
      memx_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic search(input string name, input logic [AW-1:0] base, input logic [DW-1:0] key,
                        input logic [DW-1:0] mask, input int n_reads, input logic hit,
                        input logic [IW-1:0] idx);
    for (int i = 0; i < n_reads; i++) exp_mem(K_READ, base + AW'(i), '0);
    exp_res(2'd0, hit, idx);
    send(2'd0, base, key, mask);
    wait_done(name);
  endtask

  initial begin
    int t;
    bus.cmd_vld  = 1'b0;
    bus.cmd_op   = '0;
    bus.cmd_addr = '0;
    bus.cmd_key  = '0;
    bus.cmd_mask = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
    check("reset res_vld", 64'(bus.res_vld), 64'd0);
    check("reset res_hit", 64'(bus.res_hit), 64'd0);
    check("reset res_index", 64'(bus.res_index), 64'd0);
    check("reset strobes", {61'd0, bus.mem_init, bus.mem_read, bus.mem_write}, 64'd0);
    check("reset mem_address", 64'(bus.mem_address), 64'd0);
    check("reset mem_writedata", 64'(bus.mem_writedata), 64'd0);

    exp_mem(K_INIT, '0, '0);
    exp_res(2'd2, 1'b0, '0);
    send(2'd2, '0, '0, '0);
    wait_done("init");

    exp_mem(K_WRITE, 27'h100, 32'hDEAD_BEEF);
    exp_res(2'd1, 1'b0, '0);
    send(2'd1, 27'h100, 32'hDEAD_BEEF, '0);
    wait_done("update");

    for (int i = 0; i < 16; i++) begin
      mem_arr[27'h200 + AW'(i)] = 32'(i);
      mem_arr[27'h300 + AW'(i)] = 32'(i);
    end
    mem_arr[27'h205]     = 32'hCAFE_0005;
    mem_arr[27'h303]     = 32'hCAFE_1234;
    mem_arr[27'h0000001] = 32'hA5A5_0001;

    search("search hit", 27'h200, 32'hCAFE_0005, '0, 6, 1'b1, 4'd5);
    repeat (3) @(negedge clk);
    check("res_hit held", 64'(bus.res_hit), 64'd1);
    check("res_index held", 64'(bus.res_index), 64'd5);

    exp_res(2'd3, 1'b0, '0);
    send(2'd3, 27'h200, 32'hCAFE_0005, '0);
    wait_done("reserved op");

    search("search miss", 27'h200, 32'hFFFF_FFFF, '0, 16, 1'b0, 4'd0);
    search("search last entry", 27'h200, 32'h0000_000F, '0, 16, 1'b1, 4'd15);
`ifdef TCAM_TERNARY_MASK_EN
    search("search ternary", 27'h300, 32'hCAFE_0000, 32'h0000_FFFF, 4, 1'b1, 4'd3);
`else
    search("search exact", 27'h300, 32'hCAFE_0000, 32'h0000_FFFF, 16, 1'b0, 4'd0);
`endif
    search("search wrap", 27'h7FF_FFFE, 32'hA5A5_0001, '0, 4, 1'b1, 4'd3);

    exp_mem(K_READ, 27'h200, '0);
    send(2'd0, 27'h200, 32'h0000_0005, '0);
    t = 0;
    while (!bus.mem_waitrequest && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.mem_waitrequest) fail("reset test ack timeout");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("strobes in reset", {61'd0, bus.mem_init, bus.mem_read, bus.mem_write}, 64'd0);
    check("res_vld in reset", 64'(bus.res_vld), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("cmd_rdy after reset", 64'(bus.cmd_rdy), 64'd1);
    check("no pending strobes after reset", 64'(memx_q.size()), 64'd0);

    exp_res(2'd3, 1'b0, '0);
    send(2'd3, '0, '0, '0);
    wait_done("recovery");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcam_search_engine.md
# tcam_search_engine

Command-level front end for the DDR-backed TCAM, sitting directly upstream of the SDRAM controller's Avalon-MM slave port. Accepts SEARCH, UPDATE and INIT commands, converts each into a sequence of single-word controller transactions, and compares returned words against the search key. Reports the lowest matching entry index. Owns all handshake sequencing against the controller's registered-input, level-status interface.

## Interface
- ADDR_WID, 27, controller word-address width
- DATA_WID, 32, TCAM entry / key width
- IDX_WID, 4, entry-index width; a search scans 2^IDX_WID consecutive words
- CLK  in  1  single clock
- RESET  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  engine idle, command accepted when VALID&READY
- CMD_OP  in  2  0=SEARCH, 1=UPDATE, 2=INIT, 3=reserved (accepted, completes as no-op)
- CMD_ADDR  in  ADDR_WID  SEARCH base address / UPDATE target address
- CMD_KEY  in  DATA_WID  search key / update data
- CMD_MASK  in  DATA_WID  ternary mask, bit=1 means don't-care
- RES_VALID  out  1  one-cycle completion pulse for every accepted command
- RES_HIT  out  1  SEARCH found a match (0 for other ops)
- RES_INDEX  out  IDX_WID  lowest matching index (0 when no hit)
- MEM_INIT / MEM_READ / MEM_WRITE  out  1  controller strobes, registered, one-cycle pulses
- MEM_ADDRESS  out  ADDR_WID  controller address
- MEM_WRITEDATA  out  DATA_WID  controller write data
- MEM_READDATA  in  DATA_WID  controller read data
- MEM_INITCOMPLETE  in  1  controller init-done level
- MEM_WAITREQUEST  in  1  controller busy level
- MEM_READDATAVALID  in  1  controller read-done level (high while controller idle)

## Operation
- States: IDLE, ISSUE, ACK, WAIT_RD, WAIT_WR, WAIT_INIT, COMPARE, DONE.
- IDLE: CMD_READY=1. On accept, latch OP/ADDR/KEY/MASK, clear index counter, go ISSUE (op 3 goes straight to DONE).
- ISSUE: when MEM_WAITREQUEST=0, pulse exactly one strobe for one cycle (READ for SEARCH, WRITE for UPDATE, INIT for INIT); go ACK. If WAITREQUEST=1, hold in ISSUE with no strobe.
- ACK: wait for MEM_WAITREQUEST=1 (controller registers inputs, so ack arrives ≥2 cycles after strobe), then go WAIT_RD / WAIT_WR / WAIT_INIT by op.
- WAIT_RD: on MEM_READDATAVALID=1 capture MEM_READDATA, go COMPARE. The level-high READDATAVALID seen before ACK is never sampled.
- WAIT_WR: on MEM_WAITREQUEST=0 go DONE.
- WAIT_INIT: on MEM_INITCOMPLETE=1 go DONE.
- COMPARE: hit = ((data ^ key) & ~mask) == 0. Hit → RES_HIT=1, RES_INDEX=index, DONE. Miss and index==2^IDX_WID-1 → RES_HIT=0, DONE. Otherwise index+1, ISSUE.
- MEM_ADDRESS = base + index, truncated to ADDR_WID (wraps past all-ones to 0). UPDATE: MEM_ADDRESS=CMD_ADDR, MEM_WRITEDATA=CMD_KEY.
- DONE: pulse RES_VALID one cycle, return IDLE.
- CMD_VALID while busy is ignored (CMD_READY=0); no queuing.

## Timing
- Reset values: CMD_READY=1 after reset release; RES_VALID, RES_HIT, RES_INDEX, all MEM strobes, MEM_ADDRESS, MEM_WRITEDATA = 0. State IDLE.
- RESET mid-command: strobes drop immediately, state IDLE, no RES_VALID; in-flight controller operation is abandoned.
- Accept at edge N → earliest strobe in cycle N+1 (ISSUE evaluated in N+1 with registered output at N+2 max; strobe is registered, so asserted cycle N+2 at latest when WAITREQUEST=0).
- RES_HIT/RES_INDEX valid with RES_VALID and held until next accept.
- Per-entry SEARCH cost: 1 ISSUE + ack latency + controller read latency + 1 COMPARE cycle.

## Configuration
- TCAM_TERNARY_MASK_EN defined: compare uses CMD_MASK as above.
- Undefined: exact compare (data == key); CMD_MASK ignored and its register removed.

## Test plan
- INIT: op=2 with controller model → single MEM_INIT pulse, RES_VALID after MEM_INITCOMPLETE rises, RES_HIT=0.
- UPDATE: op=1, addr=0x100, key=0xDEADBEEF → one MEM_WRITE pulse with those values, RES_VALID after WAITREQUEST falls.
- SEARCH hit: words 0x200..0x20F hold i, entry 5 = 0xCAFE0005, key=0xCAFE0005 mask=0 → 6 MEM_READs, RES_HIT=1, RES_INDEX=5.
- SEARCH ternary (macro on): key=0xCAFE0000 mask=0x0000FFFF, entry 3 = 0xCAFE1234 → RES_INDEX=3; macro off → RES_HIT=0 after 16 reads.
- Wrap: base=0x7FFFFFE → reads to 0x7FFFFFE, 0x7FFFFFF, 0x0000000….
- RESET asserted in WAIT_RD → strobes 0, CMD_READY=1 after release, no RES_VALID.
